seg7_capture: RTL
=================

// Module: seg7_capture
// PURPOSE
//   Receive side of the multiplexed 7-segment bus: samples active-low SEG[6:0]/AN[3:0],
//   waits out ghosting after each anode switch, inverse-decodes the glyph to hex and
//   latches it per digit. Used for on-board loopback self-test of the display scanner
//   and as a bench monitor; sits beside the scanner on the same SEG/AN nets.
// PARAMETERS
//   NUM_DIGITS     4      anode lines / digit slots captured (1..4)
//   SETTLE_CYCLES  8      synced AN+SEG must hold unchanged this many clks before capture
//   STALE_W        18     width of per-digit age counter; saturation clears digit_valid
// PORTS
//   clk          in   1              system clock (all logic on posedge)
//   rst          in   1              asynchronous, active-high reset
//   SEG          in   7              segment bus, active low, bit6=g .. bit0=a
//   AN           in   NUM_DIGITS     anode enables, active low, one-hot-low when driven
//   digits       out  4*NUM_DIGITS   captured hex values, digit i at [4i+3:4i]
//   digit_valid  out  NUM_DIGITS     1 = slot holds a fresh, legal glyph
//   frame_done   out  1              1-clk pulse when scan wraps back to digit 0
//   seg_err      out  1              1-clk pulse: illegal segment pattern captured
//   an_err       out  1              1-clk pulse: >1 anode low, stable SETTLE_CYCLES
// BEHAVIOUR
//   - Reset: digits=0, digit_valid=0, frame_done=0, seg_err=0, an_err=0, FSM=IDLE, counters=0,
//     sync regs=all-ones (idle bus). Reset mid-SETTLE/HOLD aborts with no capture.
//   - SEG and AN pass through 2-FF synchronisers; all decisions use stage-2 values.
//   - FSM: IDLE -> SETTLE when synced AN != all-ones.
//     SETTLE: count while {AN,SEG} equals value registered on entry; any change restarts
//     count (stays SETTLE, or -> IDLE if AN all-ones). At count==SETTLE_CYCLES-1 -> CAPTURE.
//     CAPTURE (1 clk): act per rules below -> HOLD.
//     HOLD: wait until {AN,SEG} differs from captured value -> SETTLE (or IDLE if all-ones).
//   - Latency: bus change registered by sync FF1 at edge t0; outputs update at edge
//     t0+2+SETTLE_CYCLES if bus stable. Glitch shorter than SETTLE_CYCLES: no update.
//   - CAPTURE, AN one-hot-low at index i:
//       legal glyph (16 hex codes, inverse of scanner table, e.g. 7'b0010010 -> 5,
//       7'b0001000 -> A): digits[i]=value, digit_valid[i]=1, age[i]=0.
//       7'b1111111 (blank): digit_valid[i]=0, digits[i] kept, no error.
//       any other pattern: seg_err=1, digit_valid[i]=0, digits[i] kept.
//     AN with >1 bit low: an_err=1, no slot written.
//   - frame_done pulses in the CAPTURE of index 0 when any index>0 captured since last pulse.
//   - Age: each age[i] increments every clk, saturates at all-ones; on saturation
//     digit_valid[i]=0 (stale). Capture of i on saturation cycle wins (valid=1, age=0).
//   - Error/frame pulses are registered, exactly one clk wide, same edge as digit update.
// STRUCTURE
//   - seg7_pkg: SEG_BLANK constant, 16-entry glyph table (shared with scanner encoder),
//     FSM state encodings IDLE/SETTLE/CAPTURE/HOLD.
//   - Sub-module seg7_glyph_decode: combinational SEG[6:0] -> {legal, blank, hex[3:0]}.
//   - Top: synchronisers, FSM + settle counter, per-digit age counters, output regs.
// TESTING
//   1 rst=1 then release, bus idle 100 clks -> digits=0, digit_valid=0, no pulses.
//   2 AN=4'b1110 SEG=7'b0010010 for 20 clks -> digits[3:0]=5, digit_valid=4'b0001 at t0+10.
//   3 AN=4'b1101 SEG=7'b0001000 held 5 clks then idle -> no update (glitch < SETTLE_CYCLES).
//   4 AN=4'b1110 SEG=7'b0101010 held 20 clks -> seg_err 1 pulse, digit_valid[0]=0, digits kept.
//   5 AN=4'b1100 held 20 clks -> an_err 1 pulse, no slot changes; reset during SETTLE -> no capture.
//   6 Loopback with scanner, digits 1,2,3 -> digits=16'h0321, valid=4'b0111, frame_done
//     every 65536 clks; stop scanner -> valid drops to 0 after 2^STALE_W clks.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment bus: blank pattern,
// active-low glyph table (bit6=g .. bit0=a) and capture FSM state codes.
package seg7_pkg;

    // All segments off on the active-low bus.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Glyph for hex value h sits at GLYPH_TABLE[h]. The scanner encoder uses
    // this table, and the capture decoder inverts it.
    localparam logic [15:0][6:0] GLYPH_TABLE = {
        7'h0E,  // F
        7'h06,  // E
        7'h21,  // d
        7'h46,  // C
        7'h03,  // b
        7'h08,  // A
        7'h10,  // 9
        7'h00,  // 8
        7'h78,  // 7
        7'h02,  // 6
        7'h12,  // 5
        7'h19,  // 4
        7'h30,  // 3
        7'h24,  // 2
        7'h79,  // 1
        7'h40   // 0
    };

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SETTLE  = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_HOLD    = 2'd3;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational inverse of the glyph table: active-low segment pattern to
// {legal, blank, hex}. hex is zero whenever the pattern is not a legal glyph.
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic       legal,
    output logic       blank,
    output logic [3:0] hex
);

    // Search the glyph table for the pattern; blank is flagged on its own.
    always_comb begin
        legal = 1'b0;
        hex   = '0;
        blank = (seg == SEG_BLANK);
        for (int unsigned i = 0; i < 16; i++) begin
            if (seg == GLYPH_TABLE[i]) begin
                legal = 1'b1;
                hex   = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seg7_capture.sv
// Receive side of the multiplexed 7-segment bus. Synchronises SEG/AN, waits
// for the bus to settle after each anode switch, decodes the glyph and latches
// it per digit. Digits that are not refreshed eventually go stale.
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int SETTLE_CYCLES = 8,
    parameter int STALE_W       = 18
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              SEG,
    input  logic [NUM_DIGITS-1:0]   AN,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    frame_done,
    output logic                    seg_err,
    output logic                    an_err
);

    localparam int BUS_W = NUM_DIGITS + 7;
    localparam int CNT_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SETTLE_CYCLES - 1);

    logic [NUM_DIGITS-1:0] an_s1, an_s2;
    logic [6:0]            seg_s1, seg_s2;

    logic [BUS_W-1:0]      bus;
    logic                  bus_idle;
    logic                  bus_changed;

    logic [1:0]            state;
    logic [BUS_W-1:0]      ref_bus;
    logic [CNT_W-1:0]      cnt;

    logic [NUM_DIGITS-1:0] ref_an;
    logic [NUM_DIGITS-1:0] an_low;
    logic                  an_onehot;
    logic [NUM_DIGITS-1:0] wr_sel;
    logic                  capture;
    logic                  other_sel;
    logic                  hit_other;

    logic                  glyph_legal;
    logic                  glyph_blank;
    logic [3:0]            glyph_hex;

    logic [STALE_W-1:0]    age [NUM_DIGITS];

    // Two-stage synchronisers; reset to the idle (all-ones) bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_s1  <= '1;
            an_s2  <= '1;
            seg_s1 <= '1;
            seg_s2 <= '1;
        end else begin
            an_s1  <= AN;
            an_s2  <= an_s1;
            seg_s1 <= SEG;
            seg_s2 <= seg_s1;
        end
    end

    assign bus         = {an_s2, seg_s2};
    assign bus_idle    = &an_s2;
    assign bus_changed = (bus != ref_bus);

    // Settle/capture FSM: a bus value counts as held from the cycle it is first
    // registered, so every (re)entry into SETTLE starts the count at one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            ref_bus <= '1;
            cnt     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!bus_idle) begin
                        state   <= ST_SETTLE;
                        ref_bus <= bus;
                        cnt     <= CNT_FIRST;
                    end
                end
                ST_SETTLE: begin
                    if (bus_changed) begin
                        state   <= bus_idle ? ST_IDLE : ST_SETTLE;
                        ref_bus <= bus;
                        cnt     <= bus_idle ? '0 : CNT_FIRST;
                    end else if (cnt >= CNT_LAST) begin
                        state <= ST_CAPTURE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                // CAPTURE already watches for the next change so a digit that
                // follows straight after a capture sees the same latency.
                ST_CAPTURE, ST_HOLD: begin
                    if (bus_changed) begin
                        state   <= bus_idle ? ST_IDLE : ST_SETTLE;
                        ref_bus <= bus;
                        cnt     <= bus_idle ? '0 : CNT_FIRST;
                    end else begin
                        state <= ST_HOLD;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    seg7_glyph_decode u_decode (
        .seg   (ref_bus[6:0]),
        .legal (glyph_legal),
        .blank (glyph_blank),
        .hex   (glyph_hex)
    );

    assign ref_an    = ref_bus[BUS_W-1:7];
    assign an_low    = ~ref_an;
    assign an_onehot = (an_low != '0) &&
                       ((an_low & (an_low - NUM_DIGITS'(1))) == '0);
    assign capture   = (state == ST_CAPTURE);
    assign wr_sel    = an_onehot ? an_low : '0;
    assign other_sel = |(wr_sel >> 1);

    // Per-digit slots: legal capture refreshes value and age; blank or bad
    // glyph invalidates; saturated age marks the slot stale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits      <= '0;
            digit_valid <= '0;
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                age[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (capture && wr_sel[i] && glyph_legal) begin
                    digits[4*i +: 4] <= glyph_hex;
                    digit_valid[i]   <= 1'b1;
                    age[i]           <= '0;
                end else begin
                    if (age[i] != '1) begin
                        age[i] <= age[i] + STALE_W'(1);
                    end else begin
                        digit_valid[i] <= 1'b0;
                    end
                    if (capture && wr_sel[i]) begin
                        digit_valid[i] <= 1'b0;
                    end
                end
            end
        end
    end

    // Single-cycle status pulses plus the "higher digit seen" flag that
    // qualifies frame_done on the return to digit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_done <= 1'b0;
            seg_err    <= 1'b0;
            an_err     <= 1'b0;
            hit_other  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            seg_err    <= 1'b0;
            an_err     <= 1'b0;
            if (capture) begin
                if (!an_onehot) begin
                    an_err <= 1'b1;
                end else begin
                    if (!glyph_legal && !glyph_blank) begin
                        seg_err <= 1'b1;
                    end
                    if (wr_sel[0]) begin
                        frame_done <= hit_other;
                        hit_other  <= 1'b0;
                    end else if (other_sel) begin
                        hit_other <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
